// File: rtl/spi_reg_arbiter.sv
// ---------------------------------------------------------------------------
// spi_reg_arbiter
//
// Shares one register bus between the SPI slave (bus-side request pulses,
// already synchronised to HCLK) and an on-chip host port. One access is in
// flight at a time. Each access supports target wait states and is aborted
// after TIMEOUT cycles without reg_ready. SPI has fixed priority because the
// SPI slave cannot be stalled.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   spi_wreq/spi_rreq    single-cycle SPI write/read request pulses
//   spi_addr/spi_wdata   SPI address and write data, stable with the pulse
//   spi_rdata            last SPI read result, held until the next SPI read
//   spi_ovf/spi_ovf_clr  sticky "SPI request dropped" flag and its clear
//   host_req/host_we     host level request (held until host_ack) and R/W
//   host_addr/host_wdata host address and write data
//   host_ack/host_rdata  host completion pulse and read result
//   reg_sel/reg_we       register bus access active / write qualifier
//   reg_addr/reg_wdata   register bus address and write data
//   reg_rdata/reg_ready  target read data and completion
//   err_timeout          one-cycle pulse when an access is aborted
// ---------------------------------------------------------------------------
module spi_reg_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    // SPI side
    input  logic              spi_wreq,
    input  logic              spi_rreq,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              spi_ovf,
    input  logic              spi_ovf_clr,
    // host side
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    // register bus
    output logic              reg_sel,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ready,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    // Registered state
    state_t              state_q;
    logic                pend_valid_q;
    logic                pend_we_q;
    logic [ADDR_W-1:0]   pend_addr_q;
    logic [DATA_W-1:0]   pend_wdata_q;
    logic                owner_host_q;   // 1 = current access belongs to host
    logic [CNT_W-1:0]    cnt_q;

    // Next-state values
    state_t              state_d;
    logic                pend_valid_d;
    logic                pend_we_d;
    logic [ADDR_W-1:0]   pend_addr_d;
    logic [DATA_W-1:0]   pend_wdata_d;
    logic                owner_host_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [DATA_W-1:0]   spi_rdata_d;
    logic                spi_ovf_d;
    logic                host_ack_d;
    logic [DATA_W-1:0]   host_rdata_d;
    logic                reg_sel_d;
    logic                reg_we_d;
    logic [ADDR_W-1:0]   reg_addr_d;
    logic [DATA_W-1:0]   reg_wdata_d;
    logic                err_timeout_d;

    // Helpers
    logic                spi_pulse;
    logic                spi_grant;
    logic                load_ok;
    logic                ovf_set;
    logic [CNT_W-1:0]    cnt_inc;

    assign spi_pulse = spi_wreq | spi_rreq;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_we_d     = pend_we_q;
        pend_addr_d   = pend_addr_q;
        pend_wdata_d  = pend_wdata_q;
        owner_host_d  = owner_host_q;
        cnt_d         = cnt_q;
        spi_rdata_d   = spi_rdata;
        spi_ovf_d     = spi_ovf;
        host_ack_d    = 1'b0;
        host_rdata_d  = host_rdata;
        reg_sel_d     = reg_sel;
        reg_we_d      = reg_we;
        reg_addr_d    = reg_addr;
        reg_wdata_d   = reg_wdata;
        err_timeout_d = 1'b0;
        spi_grant     = 1'b0;
        load_ok       = 1'b0;
        ovf_set       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    spi_grant    = 1'b1;
                    owner_host_d = 1'b0;
                    reg_sel_d    = 1'b1;
                    reg_we_d     = pend_we_q;
                    reg_addr_d   = pend_addr_q;
                    reg_wdata_d  = pend_wdata_q;
                    cnt_d        = '0;
                    state_d      = ST_ACCESS;
                end else if (host_req && !spi_pulse) begin
                    // An SPI pulse arriving this cycle is granted next cycle;
                    // holding the host back here keeps SPI priority intact.
                    owner_host_d = 1'b1;
                    reg_sel_d    = 1'b1;
                    reg_we_d     = host_we;
                    reg_addr_d   = host_addr;
                    reg_wdata_d  = host_wdata;
                    cnt_d        = '0;
                    state_d      = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (reg_ready) begin
                    reg_sel_d  = 1'b0;
                    host_ack_d = owner_host_q;
                    if (!reg_we) begin
                        if (owner_host_q) host_rdata_d = reg_rdata;
                        else              spi_rdata_d  = reg_rdata;
                    end
                    state_d = ST_DONE;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    // TIMEOUT ACCESS cycles have elapsed without reg_ready.
                    reg_sel_d     = 1'b0;
                    host_ack_d    = owner_host_q;
                    err_timeout_d = 1'b1;
                    if (!reg_we) begin
                        if (owner_host_q) host_rdata_d = {DATA_W{1'b1}};
                        else              spi_rdata_d  = {DATA_W{1'b1}};
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // SPI capture stage: one-deep, refillable in the cycle it is granted.
        load_ok = !pend_valid_q || spi_grant;
        if (spi_grant) pend_valid_d = 1'b0;
        if (spi_pulse && load_ok) begin
            pend_valid_d = 1'b1;
            pend_we_d    = spi_wreq;      // write wins over a coincident read
            pend_addr_d  = spi_addr;
            pend_wdata_d = spi_wdata;
        end
        ovf_set = spi_pulse && (!load_ok || (spi_wreq && spi_rreq));
        if (ovf_set)          spi_ovf_d = 1'b1;
        else if (spi_ovf_clr) spi_ovf_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_IDLE;
            pend_valid_q <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            owner_host_q <= 1'b0;
            cnt_q        <= '0;
            spi_rdata    <= '0;
            spi_ovf      <= 1'b0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
            reg_sel      <= 1'b0;
            reg_we       <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            owner_host_q <= owner_host_d;
            cnt_q        <= cnt_d;
            spi_rdata    <= spi_rdata_d;
            spi_ovf      <= spi_ovf_d;
            host_ack     <= host_ack_d;
            host_rdata   <= host_rdata_d;
            reg_sel      <= reg_sel_d;
            reg_we       <= reg_we_d;
            reg_addr     <= reg_addr_d;
            reg_wdata    <= reg_wdata_d;
            err_timeout  <= err_timeout_d;
        end
    end

endmodule
